load_store_unit: RTL

// - Sits between the MEM-stage pipeline control and the word-addressed data memory.
// - Converts byte, halfword and word load/store requests into timed word accesses.
// - Holds mem_read/mem_write for the memory's fixed access latency.
// - Performs read-modify-write for sub-word stores; aligns and extends load data.
// - Stalls the pipeline via req_ready until the access completes.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: bridges MEM-stage load/store requests to a word-addressed
// data memory with a fixed access latency of WAIT_CYCLES cycles.
// Sub-word stores use read-modify-write. Loads are lane-aligned and then
// sign- or zero-extended. req_ready stalls the pipeline until the access ends.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word
// requests (resp_err=1, no memory access). Without it, resp_err is tied 0 and
// misaligned accesses are aligned down.
module load_store_unit #(
  parameter int WAIT_CYCLES = 4,
  parameter int ADDR_W      = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_last;
  logic              accept;
  logic              misaligned;

  // Request fields latched on accept; they stay stable for the whole access.
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       resp_data_q;

  // Address bits above the memory depth are deliberately dropped (wrap-around).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  // Extract the addressed lane(s) of a memory word and extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic        sgn,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extend = {{24{sgn & b[7]}}, b};
      2'b01:   load_extend = {{16{sgn & h[15]}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] merged;
    merged = old;
    case (size)
      2'b00:   merged[{lane, 3'b000} +: 8]      = wdata[7:0];
      2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
    store_merge = merged;
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic err_q;

  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
  assign resp_err   = (state == DONE) && err_q;

  // Remember whether the accepted request was trapped as misaligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign resp_err   = 1'b0;
`endif

  assign accept   = (state == IDLE) && req_valid;
  assign cnt_last = (cnt == CNT_LAST);

  // State register and per-state cycle counter.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if ((state_next != state) || (state == IDLE)) cnt <= '0;
      else                                          cnt <= cnt + 1'b1;
    end
  end

  // Next-state decode and per-state control outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)                state_next = DONE;
          else if (req_we && req_size[1]) state_next = WRITE;
          else                            state_next = READ;
        end
      end
      READ: begin
        mem_read = 1'b1;
        if (cnt_last) state_next = we_q ? WRITE : DONE;
      end
      WRITE: begin
        mem_write = 1'b1;
        if (cnt_last) state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, read-data capture and load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      resp_data_q <= 32'h0;
    end else if (accept) begin
      we_q        <= req_we;
      size_q      <= req_size;
      signed_q    <= req_signed;
      addr_q      <= req_addr[ADDR_W+1:0];
      wdata_q     <= req_wdata;
      resp_data_q <= 32'h0;
    end else if ((state == READ) && cnt_last) begin
      rdata_q <= mem_rdata;
      if (!we_q) resp_data_q <= load_extend(mem_rdata, size_q, signed_q, addr_q[1:0]);
    end
  end

  assign mem_addr  = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
  assign mem_wdata = (state == WRITE) ? store_merge(rdata_q, wdata_q, size_q, addr_q[1:0])
                                      : 32'h0;
  assign resp_data = resp_data_q;

endmodule
